// File: rtl/pci_pkg.sv
// Shared definitions for the PCI memory-space target: bus command codes,
// controller state encoding and the decode result bundle.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RD_TA,
    ST_DATA,
    ST_DISC,
    ST_TURN
  } state_e;

  typedef struct packed {
    logic       hit;
    logic       is_rd;
    logic       is_wr;
    logic [1:0] word_idx;
  } dec_t;

endpackage

// File: rtl/pci_target_decode.sv
// Combinational claim decode: memory read/write command, base match on
// address bits [31:4] and word index inside the attached storage depth.
module pci_target_decode
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 3
) (
  input  logic [31:2] addr,
  input  logic [3:0]  cmd,
  output dec_t        dec
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  logic base_match;
  logic idx_ok;

  always_comb begin
    dec.is_rd    = (cmd == CMD_MEM_RD);
    dec.is_wr    = (cmd == CMD_MEM_WR);
    dec.word_idx = addr[3:2];
    base_match   = (addr[31:4] == BASE_ADDR[31:4]);
    idx_ok       = ({1'b0, addr[3:2]} < DEPTH_L);
    dec.hit      = (dec.is_rd || dec.is_wr) && base_match && idx_ok;
  end

endmodule

// File: rtl/pci_target_ctrl.sv
// PCI memory-space target controller: claims matching single and linear burst
// transfers, drives DEVSEL#/TRDY#/STOP# and a word-addressed storage port.
module pci_target_ctrl
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad_in,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n,
  output logic [1:0]  mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [3:0]  mem_be
);

  // state  | meaning
  // IDLE   | bus watched for a FRAME# falling edge
  // DECODE | latched address/command being decoded
  // RD_TA  | read turnaround: DEVSEL# low, TRDY# still high
  // DATA   | data phases, TRDY# low, transfer whenever IRDY# is low
  // DISC   | storage exhausted: STOP# low until FRAME# is released
  // TURN   | all target signals released for one cycle

  localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);

  state_e      state_q, state_d;
  logic        frame_prev_q, frame_prev_d;
  logic        ignore_q, ignore_d;
  logic [31:2] addr_q, addr_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  mem_addr_q, mem_addr_d;
  logic        devsel_q, devsel_d;
  logic        trdy_q, trdy_d;
  logic        stop_q, stop_d;
  logic        re_q, re_d;
  logic        xfer;
  dec_t        dec;
  logic        unused_addr_lo;

  assign unused_addr_lo = ^ad_in[1:0];

  pci_target_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_decode (
    .addr (addr_q),
    .cmd  (cmd_q),
    .dec  (dec)
  );

  always_comb begin
    state_d      = state_q;
    frame_prev_d = frame_n;
    ignore_d     = ignore_q;
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    mem_addr_d   = mem_addr_q;
    devsel_d     = devsel_q;
    trdy_d       = trdy_q;
    stop_d       = stop_q;
    re_d         = re_q;
    xfer         = (state_q == ST_DATA) && !irdy_n;

    // A missed transaction stays ignored until the bus goes fully idle.
    if (ignore_q && frame_n && irdy_n) begin
      ignore_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!frame_n && frame_prev_q && !ignore_q) begin
          addr_d  = ad_in[31:2];
          cmd_d   = cbe_n;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.hit && dec.is_wr) begin
          mem_addr_d = dec.word_idx;
          devsel_d   = 1'b0;
          trdy_d     = 1'b0;
          state_d    = ST_DATA;
        end else if (dec.hit && dec.is_rd) begin
          mem_addr_d = dec.word_idx;
          devsel_d   = 1'b0;
          re_d       = 1'b1;
          state_d    = ST_RD_TA;
        end else begin
          ignore_d = !(frame_n && irdy_n);
          state_d  = ST_IDLE;
        end
      end
      ST_RD_TA: begin
        trdy_d  = 1'b0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (xfer) begin
          if (mem_addr_q != LAST_IDX) begin
            mem_addr_d = mem_addr_q + 2'd1;
          end
          if (frame_n) begin
            devsel_d = 1'b1;
            trdy_d   = 1'b1;
            re_d     = 1'b0;
            state_d  = ST_TURN;
          end else if (mem_addr_q == LAST_IDX) begin
            trdy_d  = 1'b1;
            stop_d  = 1'b0;
            re_d    = 1'b0;
            state_d = ST_DISC;
          end
        end
      end
      ST_DISC: begin
        if (frame_n) begin
          devsel_d = 1'b1;
          stop_d   = 1'b1;
          state_d  = ST_TURN;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        devsel_d = 1'b1;
        trdy_d   = 1'b1;
        stop_d   = 1'b1;
        re_d     = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Frame history resets low so a frame already asserted at reset release
  // is not mistaken for a new falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_prev_q <= 1'b0;
      ignore_q     <= 1'b0;
      addr_q       <= '0;
      cmd_q        <= '0;
      mem_addr_q   <= '0;
      devsel_q     <= 1'b1;
      trdy_q       <= 1'b1;
      stop_q       <= 1'b1;
      re_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_prev_d;
      ignore_q     <= ignore_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      mem_addr_q   <= mem_addr_d;
      devsel_q     <= devsel_d;
      trdy_q       <= trdy_d;
      stop_q       <= stop_d;
      re_q         <= re_d;
    end
  end

  // Write strobe is combinational so storage captures on the transfer edge.
  always_comb begin
    mem_we = 1'b0;
    mem_be = 4'h0;
    if (xfer && dec.is_wr) begin
      mem_we = 1'b1;
      mem_be = ~cbe_n;
    end
  end

  assign devsel_n = devsel_q;
  assign trdy_n   = trdy_q;
  assign stop_n   = stop_q;
  assign mem_addr = mem_addr_q;
  assign mem_re   = re_q;

endmodule

// File: doc/pci_target_ctrl.md
PCI_TARGET_CTRL -- requirements
Module: pci_target_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, memory-space base address; bits [3:0] ignored.
REQ-002 Parameter DEPTH, default 3, number of 32-bit words in the attached storage (1..4).
REQ-003 Port clk  in  1  system clock; all state changes on rising edge.
REQ-004 Port rst  in  1  reset; one clock, asynchronous, active-high.
REQ-005 Port frame_n  in  1  PCI FRAME#, active-low.
REQ-006 Port irdy_n  in  1  PCI IRDY#, active-low.
REQ-007 Port cbe_n  in  4  PCI C/BE#; command in the address phase, byte enables (active-low) in data phases.
REQ-008 Port ad_in  in  32  AD bus as sampled by target; address in the address phase.
REQ-009 Port devsel_n  out  1  PCI DEVSEL#, active-low.
REQ-010 Port trdy_n  out  1  PCI TRDY#, active-low.
REQ-011 Port stop_n  out  1  PCI STOP#, active-low.
REQ-012 Port mem_addr  out  2  word index to storage.
REQ-013 Port mem_re  out  1  storage read enable; storage drives AD while high.
REQ-014 Port mem_we  out  1  storage write strobe.
REQ-015 Port mem_be  out  4  active-high byte enables to storage (inverted cbe_n).

Function
REQ-016 FSM states: IDLE, DECODE, RD_TA, DATA, DISC, TURN.
REQ-017 IDLE: on edge sampling frame_n=0 (previous frame_n=1), latch ad_in and cbe_n command; go to DECODE.
REQ-018 Hit: command 4'b0110 (mem read) or 4'b0111 (mem write), addr[31:4]==BASE_ADDR[31:4], addr[3:2]<DEPTH; mem_addr loads addr[3:2].
REQ-019 DECODE, miss: return to IDLE with no output asserted; stay ignoring until frame_n=1 and irdy_n=1.
REQ-020 DECODE, hit: devsel_n=0 from next cycle; write -> DATA (trdy_n=0 same cycle as devsel_n); read -> RD_TA for one turnaround cycle, then DATA.
REQ-021 mem_re SHALL be high from RD_TA through the end of DATA for reads, low otherwise.
REQ-022 Transfer occurs at a rising edge with state DATA, irdy_n=0, trdy_n=0; master-inserted wait states (irdy_n=1) hold all outputs and mem_addr.
REQ-023 mem_we SHALL equal (state DATA & write & irdy_n==0), combinational, so storage captures on the transfer edge; mem_be=~cbe_n during that cycle.
REQ-024 After each transfer mem_addr increments by 1 (linear burst).
REQ-025 Transfer with frame_n=1 (last phase) -> TURN.
REQ-026 Transfer at mem_addr==DEPTH-1 with frame_n=0 -> DISC: trdy_n=1, stop_n=0, devsel_n=0, no further transfers, until frame_n=1 is sampled, then TURN.
REQ-027 TURN: devsel_n, trdy_n, stop_n driven 1, mem_re=0 for one cycle; then IDLE.
REQ-028 frame_n rising while irdy_n=1 SHALL not end the transaction; the next transfer completes it.
REQ-029 Never wrap mem_addr past DEPTH-1; mem_we never asserted outside DATA.

Reset
REQ-030 rst=1 forces immediately: state IDLE, devsel_n=1, trdy_n=1, stop_n=1, mem_re=0, mem_we=0, mem_addr=0, mem_be=0, latched command cleared.
REQ-031 rst asserted mid-transaction abandons it; after release the FSM re-arms only after a new frame_n falling edge.

Structure
REQ-032 Shared package pci_pkg: command codes CMD_MEM_RD=4'b0110, CMD_MEM_WR=4'b0111, FSM state enum.
REQ-033 One sub-module pci_target_decode: combinational hit/command/word-index decode from latched address and command.

Verification
REQ-034 Single write: addr 0x0, cmd 0111, data phase frame_n=1 irdy_n=0 -> devsel_n/trdy_n low 1 cycle after DECODE, one mem_we pulse, mem_addr=0, TURN then IDLE.
REQ-035 Burst write 3 words from addr 0x0, frame_n held low -> mem_we at mem_addr 0,1,2; after third transfer stop_n=0, trdy_n=1 until frame_n=1.
REQ-036 Burst read 2 words from addr 0x4 -> RD_TA turnaround cycle with trdy_n=1, then transfers at mem_addr 1,2; mem_re high throughout, low in TURN.
REQ-037 Miss: addr 0x0000_0100 or cmd 0010 -> devsel_n, trdy_n, stop_n stay 1; mem_re/mem_we never asserted.
REQ-038 Master wait: irdy_n=1 for 2 cycles mid-burst -> mem_addr and outputs hold; no mem_we.
REQ-039 rst pulse during second write phase -> all outputs at reset values same cycle; no transfer until next frame_n fall.
